vx_issue_sched: RTL and testbench
=================================

// Module: vx_issue_sched
// PURPOSE
//  Parametrised issue scheduler: per-warp instruction buffers, per-warp register scoreboard and round-robin warp select.
//  Sits between decode and operand fetch/dispatch; one instruction issued per cycle into a registered output stage.
//  Generalises the fixed issue path to NUM_WARPS warps with configurable buffer depth, register count and payload width.
// PARAMETERS
//  NUM_WARPS     4   warps tracked (>=1); NW_BITS = max(1,$clog2(NUM_WARPS))
//  IBUF_DEPTH    4   entries per warp buffer (>=2); CNT_BITS = $clog2(IBUF_DEPTH+1)
//  NUM_REGS      32  architectural registers per warp; NR_BITS = $clog2(NUM_REGS)
//  DATAW         64  opaque instruction payload width (op, imm, tmask, PC, ...)
//  PERF_CTR_BITS 44  width of perf counters (ISSUE_PERF_EN only)
// PORTS
//  clk           in  1        clock
//  reset         in  1        asynchronous, active-low reset (0 = in reset)
//  dec_valid     in  1        decode instruction valid
//  dec_ready     out 1        buffer of dec_wid has space
//  dec_wid       in  NW_BITS  warp id
//  dec_wb        in  1        instruction writes rd
//  dec_rd        in  NR_BITS  destination register
//  dec_rs1/2/3   in  NR_BITS  source registers (three ports)
//  dec_data      in  DATAW    payload
//  iss_valid     out 1        issued instruction valid (registered)
//  iss_ready     in  1        downstream accepts
//  iss_wid       out NW_BITS  warp id of issued instruction
//  iss_wb/iss_rd out 1/NR_BITS writeback flag / destination
//  iss_data      out DATAW    payload
//  wb_valid      in  1        writeback valid
//  wb_wid/wb_rd  in  NW_BITS/NR_BITS  writeback warp / register
//  wb_eop        in  1        last packet of writeback; only eop releases the register
//  perf_ibf_stalls out PERF_CTR_BITS  (ISSUE_PERF_EN) decode-stall cycles
//  perf_scb_stalls out PERF_CTR_BITS  (ISSUE_PERF_EN) scoreboard-stall cycles
// BEHAVIOUR
//  - Reset (async assert, sync release): all buffers empty, pending bits 0, RR pointer 0, iss_valid 0, iss_* payload 0, counters 0.
//    Reset mid-operation drops all buffered/in-flight entries; no writeback is expected for them.
//  - dec_ready = (count[dec_wid] != IBUF_DEPTH); combinational on dec_wid only. No pass-through: full warp stays not-ready
//    even if it pops the same cycle. Push on dec_valid&&dec_ready.
//  - Head of warp w is eligible when non-empty and pending[w] has none of rs1,rs2,rs3 set and, if wb, rd not set (RAW+WAW).
//  - Register 0 never set in pending (rd=0 writes untracked; rs=0 never blocks).
//  - Output register loads when !iss_valid || iss_ready. If loading and any warp is eligible, grant first eligible warp at or after
//    RR pointer (wrapping at NUM_WARPS-1 -> 0); pop its head, load iss_*, set iss_valid, pointer <= grant+1 (mod NUM_WARPS),
//    set pending[grant][rd] if wb && rd!=0. If loading and none eligible: iss_valid <= 0.
//  - Latency: push at edge N -> head visible after N -> earliest iss_valid after edge N+1 (2 cycles decode-to-issue, empty buffer).
//  - Per-warp order strictly FIFO; a blocked head blocks its own warp only.
//  - Writeback: wb_valid&&wb_eop clears pending[wb_wid][wb_rd] at the edge; no same-cycle bypass into eligibility (visible next cycle).
//    Same-edge set and clear of the same bit: set wins. Clear of non-pending bit: no effect.
//  - Push and pop of the same warp in one cycle: count unchanged; buffer pointers wrap modulo IBUF_DEPTH.
// CONFIGURATION
//  ISSUE_PERF_EN defined: perf_ibf_stalls += 1 each cycle dec_valid && !dec_ready; perf_scb_stalls += 1 each cycle output register
//    is loadable, at least one warp non-empty and none eligible. Counters wrap modulo 2^PERF_CTR_BITS.
//  ISSUE_PERF_EN undefined: perf ports and counter logic absent; functional behaviour identical.
// STRUCTURE
//  vx_issue_pkg: ibuf entry struct {wb, rd, rs1, rs2, rs3, data}, width localparams derivation helpers.
//  Sub-module vx_issue_warp_fifo (depth IBUF_DEPTH, entry struct, push/pop, count, head out), generated NUM_WARPS times.
//  Top holds pending[NUM_WARPS][NUM_REGS], RR arbiter, output register, perf counters.
// TESTING
//  1 Reset: drive reset=0 mid-traffic -> iss_valid=0, dec_ready=1 for all wids, pending cleared, no stale issue after release.
//  2 Latency: push w0 add rd=5 into empty unit, iss_ready=1 -> iss_valid after 2 edges, iss_wid=0, iss_rd=5.
//  3 RAW: w1 rd=7 then w1 rs1=7 -> second held until wb_valid,wb_eop,wb_wid=1,wb_rd=7; issues 1 cycle after clear; wb_eop=0 does not release.
//  4 Round-robin: all 4 warps with independent instrs, iss_ready=1 -> iss_wid sequence 0,1,2,3,0,...; w2 blocked -> 0,1,3,0,1,3.
//  5 Full/backpressure: IBUF_DEPTH=4, iss_ready=0, push 5 to w3 -> dec_ready=0 on 5th, payloads later issue in order;
//    with ISSUE_PERF_EN perf_ibf_stalls counts exactly the stalled cycles.
//  6 rd=0 / same-edge: w0 rd=0 write never blocks rs=0 reader; wb clear and new set of the same reg in one edge -> bit remains set.

Source files
------------

// File: rtl/vx_issue_pkg.sv
// Shared types and width helpers for the issue scheduler.
// Optional feature macro used by the top: ISSUE_PERF_EN (stall perf counters).
package vx_issue_pkg;

  localparam int DEF_NUM_WARPS  = 4;
  localparam int DEF_IBUF_DEPTH = 4;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_DATAW      = 64;

  function automatic int nw_bits(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int nr_bits(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Buffer entry for the default configuration; the top derives the same
  // layout from its own parameters.
  typedef struct packed {
    logic                                wb;
    logic [$clog2(DEF_NUM_REGS)-1:0]     rd;
    logic [$clog2(DEF_NUM_REGS)-1:0]     rs1;
    logic [$clog2(DEF_NUM_REGS)-1:0]     rs2;
    logic [$clog2(DEF_NUM_REGS)-1:0]     rs3;
    logic [DEF_DATAW-1:0]                data;
  } ibuf_entry_t;

endpackage

// File: rtl/vx_issue_warp_fifo.sv
// Per-warp instruction buffer: circular FIFO of DEPTH entries exposing its head.
// Caller guarantees no push when full and no pop when empty.
module vx_issue_warp_fifo
  import vx_issue_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter type entry_t  = ibuf_entry_t,
  localparam int CNT_BITS = cnt_bits(DEPTH),
  localparam int PTR_BITS = ptr_bits(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  entry_t              push_data,
  input  logic                pop,
  output entry_t              head,
  output logic [CNT_BITS-1:0] count,
  output logic                empty
);

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  // Wrap explicitly so non power-of-two depths work.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/vx_issue_sched.sv
// Issue scheduler: per-warp buffers, per-warp register scoreboard, round-robin select
// into a registered issue stage. Define ISSUE_PERF_EN to add the stall perf counters.
module vx_issue_sched
  import vx_issue_pkg::*;
#(
  parameter int  NUM_WARPS     = 4,
  parameter int  IBUF_DEPTH    = 4,
  parameter int  NUM_REGS      = 32,
  parameter int  DATAW         = 64,
  parameter int  PERF_CTR_BITS = 44,
  localparam int NW_BITS       = nw_bits(NUM_WARPS),
  localparam int CNT_BITS      = cnt_bits(IBUF_DEPTH),
  localparam int NR_BITS       = nr_bits(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [NW_BITS-1:0] dec_wid,
  input  logic               dec_wb,
  input  logic [NR_BITS-1:0] dec_rd,
  input  logic [NR_BITS-1:0] dec_rs1,
  input  logic [NR_BITS-1:0] dec_rs2,
  input  logic [NR_BITS-1:0] dec_rs3,
  input  logic [DATAW-1:0]   dec_data,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [NW_BITS-1:0] iss_wid,
  output logic               iss_wb,
  output logic [NR_BITS-1:0] iss_rd,
  output logic [DATAW-1:0]   iss_data,
  input  logic               wb_valid,
  input  logic [NW_BITS-1:0] wb_wid,
  input  logic [NR_BITS-1:0] wb_rd,
  input  logic               wb_eop
`ifdef ISSUE_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_ibf_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_scb_stalls
`endif
);

  if (NUM_WARPS < 1 || IBUF_DEPTH < 2 || NUM_REGS < 2 || PERF_CTR_BITS < 1) begin : g_bad_cfg
    $error("vx_issue_sched: unsupported parameter set");
  end

  typedef struct packed {
    logic               wb;
    logic [NR_BITS-1:0] rd;
    logic [NR_BITS-1:0] rs1;
    logic [NR_BITS-1:0] rs2;
    logic [NR_BITS-1:0] rs3;
    logic [DATAW-1:0]   data;
  } entry_t;

  entry_t               dec_entry;
  entry_t               fifo_head  [NUM_WARPS];
  logic [CNT_BITS-1:0]  fifo_count [NUM_WARPS];
  logic [NUM_WARPS-1:0] fifo_empty;
  logic [NUM_WARPS-1:0] push;
  logic [NUM_WARPS-1:0] pop;
  logic [NUM_WARPS-1:0] elig;

  logic [NUM_REGS-1:0]  pending_q [NUM_WARPS];
  logic [NUM_REGS-1:0]  pending_d [NUM_WARPS];
  logic [NW_BITS-1:0]   rr_q, rr_d;

  logic                 iss_valid_q, iss_valid_d;
  logic [NW_BITS-1:0]   iss_wid_q, iss_wid_d;
  logic                 iss_wb_q, iss_wb_d;
  logic [NR_BITS-1:0]   iss_rd_q, iss_rd_d;
  logic [DATAW-1:0]     iss_data_q, iss_data_d;

  logic                 load;
  logic                 grant_vld;
  logic [NW_BITS-1:0]   grant_w;
  entry_t               sel;

  assign dec_entry = '{wb: dec_wb, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                       rs3: dec_rs3, data: dec_data};

  // Ready depends only on the addressed warp's occupancy: a full warp is not
  // ready even when it pops in the same cycle.
  always_comb begin
    dec_ready = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (dec_wid == NW_BITS'(w)) dec_ready = (fifo_count[w] != CNT_BITS'(IBUF_DEPTH));
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push[w] = dec_valid && dec_ready && (dec_wid == NW_BITS'(w));
    assign pop[w]  = load && grant_vld && (grant_w == NW_BITS'(w));

    vx_issue_warp_fifo #(
      .DEPTH   (IBUF_DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[w]),
      .push_data (dec_entry),
      .pop       (pop[w]),
      .head      (fifo_head[w]),
      .count     (fifo_count[w]),
      .empty     (fifo_empty[w])
    );

    // Register 0 is never marked pending, so rs/rd of 0 never block.
    assign elig[w] = !fifo_empty[w]
                  && !pending_q[w][fifo_head[w].rs1]
                  && !pending_q[w][fifo_head[w].rs2]
                  && !pending_q[w][fifo_head[w].rs3]
                  && !(fifo_head[w].wb && pending_q[w][fifo_head[w].rd]);
  end

  assign load = !iss_valid_q || iss_ready;

  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_w   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_w   = NW_BITS'(idx);
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (grant_w == NW_BITS'(w)) sel = fifo_head[w];
    end
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_wid_d   = iss_wid_q;
    iss_wb_d    = iss_wb_q;
    iss_rd_d    = iss_rd_q;
    iss_data_d  = iss_data_q;
    rr_d        = rr_q;
    if (load) begin
      iss_valid_d = grant_vld;
      if (grant_vld) begin
        iss_wid_d  = grant_w;
        iss_wb_d   = sel.wb;
        iss_rd_d   = sel.rd;
        iss_data_d = sel.data;
        rr_d       = (grant_w == NW_BITS'(NUM_WARPS - 1)) ? '0 : grant_w + 1'b1;
      end
    end
  end

  // Clear first, then set, so a same-edge set of the same bit wins.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      pending_d[w] = pending_q[w];
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wb_valid && wb_eop && (wb_wid == NW_BITS'(w)) && (wb_rd == NR_BITS'(r)))
          pending_d[w][r] = 1'b0;
        if (pop[w] && sel.wb && (sel.rd == NR_BITS'(r)))
          pending_d[w][r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) pending_q[w] <= '0;
      rr_q        <= '0;
      iss_valid_q <= 1'b0;
      iss_wid_q   <= '0;
      iss_wb_q    <= 1'b0;
      iss_rd_q    <= '0;
      iss_data_q  <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) pending_q[w] <= pending_d[w];
      rr_q        <= rr_d;
      iss_valid_q <= iss_valid_d;
      iss_wid_q   <= iss_wid_d;
      iss_wb_q    <= iss_wb_d;
      iss_rd_q    <= iss_rd_d;
      iss_data_q  <= iss_data_d;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_wid   = iss_wid_q;
  assign iss_wb    = iss_wb_q;
  assign iss_rd    = iss_rd_q;
  assign iss_data  = iss_data_q;

`ifdef ISSUE_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_ibf_q, perf_ibf_d;
  logic [PERF_CTR_BITS-1:0] perf_scb_q, perf_scb_d;

  always_comb begin
    perf_ibf_d = perf_ibf_q;
    perf_scb_d = perf_scb_q;
    if (dec_valid && !dec_ready) perf_ibf_d = perf_ibf_q + 1'b1;
    if (load && !(&fifo_empty) && !grant_vld) perf_scb_d = perf_scb_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ibf_q <= '0;
      perf_scb_q <= '0;
    end else begin
      perf_ibf_q <= perf_ibf_d;
      perf_scb_q <= perf_scb_d;
    end
  end

  assign perf_ibf_stalls = perf_ibf_q;
  assign perf_scb_stalls = perf_scb_q;
`endif

endmodule

// File: tb/tb_vx_issue_sched.sv
// Self-checking bench for vx_issue_sched: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_vx_issue_sched;
  localparam int NW = 4, DEPTH = 4, NR = 32, DW = 64, PCB = 44;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dec_valid = 1'b0, dec_ready, dec_wb = 1'b0;
  logic [1:0]    dec_wid = '0;
  logic [4:0]    dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0, dec_rs3 = '0;
  logic [DW-1:0] dec_data = '0;
  logic          iss_valid, iss_ready = 1'b0, iss_wb;
  logic [1:0]    iss_wid;
  logic [4:0]    iss_rd;
  logic [DW-1:0] iss_data;
  logic          wb_valid = 1'b0, wb_eop = 1'b0;
  logic [1:0]    wb_wid = '0;
  logic [4:0]    wb_rd = '0;
`ifdef ISSUE_PERF_EN
  logic [PCB-1:0] perf_ibf_stalls, perf_scb_stalls;
`endif

  always #5 clk = ~clk;

  vx_issue_sched #(.NUM_WARPS(NW), .IBUF_DEPTH(DEPTH), .NUM_REGS(NR), .DATAW(DW),
                   .PERF_CTR_BITS(PCB)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_wid(dec_wid), .dec_wb(dec_wb),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3),
    .dec_data(dec_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wid(iss_wid), .iss_wb(iss_wb),
    .iss_rd(iss_rd), .iss_data(iss_data),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop)
`ifdef ISSUE_PERF_EN
    , .perf_ibf_stalls(perf_ibf_stalls), .perf_scb_stalls(perf_scb_stalls)
`endif
  );

  // Reference model: one queue per warp, a pending-register table, a pointer.
  typedef struct {
    bit              wb;
    int              rd, rs1, rs2, rs3;
    logic [DW-1:0]   data;
  } ins_t;

  ins_t   mq [NW][$];
  bit     m_pend [NW][NR];
  int     m_rr;
  bit     m_iv;
  ins_t   m_iss;
  int     m_iwid;
  longint m_ibf, m_scb;

  int vectors = 0;
  int errors  = 0;

  function automatic bit elig(input int w);
    ins_t h;
    if (mq[w].size() == 0) return 1'b0;
    h = mq[w][0];
    if (m_pend[w][h.rs1] || m_pend[w][h.rs2] || m_pend[w][h.rs3]) return 1'b0;
    if (h.wb && m_pend[w][h.rd]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      mq[w].delete();
      for (int r = 0; r < NR; r++) m_pend[w][r] = 1'b0;
    end
    m_rr = 0; m_iv = 1'b0; m_iwid = 0; m_ibf = 0; m_scb = 0;
    m_iss = '{wb: 1'b0, rd: 0, rs1: 0, rs2: 0, rs3: 0, data: '0};
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_wb = 1'b0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rs3 = '0;
    wb_valid = 1'b0; wb_eop = 1'b0;
  endtask

  task automatic set_dec(input int w, input bit wb, input int rd, input int rs1,
                         input int rs2, input int rs3, input logic [DW-1:0] d);
    dec_valid = 1'b1; dec_wid = 2'(w); dec_wb = wb; dec_rd = 5'(rd);
    dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rs3 = 5'(rs3); dec_data = d;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit   load, found, push, any_ne, wbc;
    int   g, dw, wbw, wbr;
    ins_t e, n;
    dw   = int'(dec_wid);
    push = dec_valid && (mq[dw].size() < DEPTH);
    load = !m_iv || iss_ready;
    wbc  = wb_valid && wb_eop;
    wbw  = int'(wb_wid);
    wbr  = int'(wb_rd);
    n    = '{wb: dec_wb, rd: int'(dec_rd), rs1: int'(dec_rs1), rs2: int'(dec_rs2),
             rs3: int'(dec_rs3), data: dec_data};
    found = 1'b0; g = 0; any_ne = 1'b0;
    e = '{wb: 1'b0, rd: 0, rs1: 0, rs2: 0, rs3: 0, data: '0};
    for (int i = 0; i < NW; i++) begin
      int w;
      w = (m_rr + i) % NW;
      if (mq[w].size() != 0) any_ne = 1'b1;
      if (load && !found && elig(w)) begin found = 1'b1; g = w; end
    end
    if (dec_valid && !push) m_ibf++;
    if (load && any_ne && !found) m_scb++;
    @(posedge clk);
    if (load) begin
      m_iv = found;
      if (found) begin
        e = mq[g].pop_front();
        m_iss = e; m_iwid = g; m_rr = (g + 1) % NW;
      end
    end
    if (wbc) m_pend[wbw][wbr] = 1'b0;
    if (load && found && e.wb && e.rd != 0) m_pend[g][e.rd] = 1'b1;
    if (push) mq[dw].push_back(n);
    #1;
  endtask

  task automatic do_reset();
    idle();
    iss_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", iss_valid); end
    vectors++; if (iss_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", iss_data); end
    vectors++; if ({iss_wid, iss_wb, iss_rd} !== '0) begin errors++; $display("FAIL rst_fields: got %h want 0", {iss_wid, iss_wb, iss_rd}); end
    // Build state: pending r3 on warp 0 and buffered entries elsewhere.
    set_dec(0, 1, 3, 0, 0, 0, 64'h11); tick();
    set_dec(1, 1, 4, 0, 0, 0, 64'h12); tick();
    set_dec(2, 0, 0, 0, 0, 0, 64'h13); tick();
    idle();
    #2 reset = 1'b0;
    #1;
    vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", iss_valid); end
    for (int w = 0; w < NW; w++) begin
      dec_wid = 2'(w); #1;
      vectors++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rst_ready w%0d: got %b want 1", w, dec_ready); end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    iss_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rst_stale %0d: got %b want 0", k, iss_valid); end
    end
    set_dec(0, 0, 0, 3, 0, 0, 64'h99); tick();
    idle(); tick();
    vectors++; if (iss_valid !== 1'b1 || iss_data !== 64'h99) begin errors++; $display("FAIL rst_pend_clear: got v=%b d=%h want v=1 d=99", iss_valid, iss_data); end
  endtask

  task automatic test_latency();
    do_reset();
    iss_ready = 1'b1;
    set_dec(0, 1, 5, 1, 2, 3, 64'h55); tick();
    vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", iss_valid); end
    idle(); tick();
    vectors++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b want 1", iss_valid); end
    vectors++; if (iss_wid !== 2'd0 || iss_rd !== 5'd5 || iss_wb !== 1'b1 || iss_data !== 64'h55) begin
      errors++; $display("FAIL lat_fields: got w=%0d rd=%0d wb=%b d=%h want w=0 rd=5 wb=1 d=55", iss_wid, iss_rd, iss_wb, iss_data); end
  endtask

  task automatic test_raw();
    do_reset();
    iss_ready = 1'b1;
    set_dec(1, 1, 7, 0, 0, 0, 64'hA7); tick();
    set_dec(1, 0, 0, 7, 0, 0, 64'hB7); tick();
    vectors++; if (iss_valid !== 1'b1 || iss_rd !== 5'd7) begin errors++; $display("FAIL raw_first: got v=%b rd=%0d want v=1 rd=7", iss_valid, iss_rd); end
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL raw_hold %0d: got %b want 0", k, iss_valid); end
    end
    wb_valid = 1'b1; wb_wid = 2'd1; wb_rd = 5'd7; wb_eop = 1'b0; tick();
    idle(); tick();
    vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL raw_no_eop: got %b want 0", iss_valid); end
    wb_valid = 1'b1; wb_wid = 2'd1; wb_rd = 5'd7; wb_eop = 1'b1; tick();
    vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got %b want 0", iss_valid); end
    idle(); tick();
    vectors++; if (iss_valid !== 1'b1 || iss_wid !== 2'd1 || iss_data !== 64'hB7) begin
      errors++; $display("FAIL raw_release: got v=%b w=%0d d=%h want v=1 w=1 d=b7", iss_valid, iss_wid, iss_data); end
  endtask

  task automatic test_round_robin();
    int exp_w [6] = '{3, 0, 1, 3, 0, 1};
    int exp_d [6] = '{'h212, 'h210, 'h211, 'h215, 'h213, 'h214};
    int blk   [6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_dec(k % 4, 0, 0, 0, 0, 0, 64'(32'h100 + k)); tick();
    end
    idle(); iss_ready = 1'b1;
    vectors++; if (iss_valid !== 1'b1 || iss_wid !== 2'd0) begin errors++; $display("FAIL rr_head: got v=%b w=%0d want v=1 w=0", iss_valid, iss_wid); end
    for (int k = 1; k < 8; k++) begin
      tick();
      vectors++; if (iss_wid !== 2'(k % 4) || iss_data !== 64'(32'h100 + k)) begin
        errors++; $display("FAIL rr_seq %0d: got w=%0d d=%h want w=%0d d=%h", k, iss_wid, iss_data, k % 4, 32'h100 + k); end
    end
    // Warp 2 blocked on RAW: the others keep rotating around it.
    do_reset();
    iss_ready = 1'b1;
    set_dec(2, 1, 9, 0, 0, 0, 64'h200); tick();
    set_dec(2, 0, 0, 9, 0, 0, 64'h201); tick();
    iss_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_dec(blk[k], 0, 0, 0, 0, 0, 64'(32'h210 + k)); tick();
    end
    idle(); iss_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++; if (iss_valid !== 1'b1 || iss_wid !== 2'(exp_w[k]) || iss_data !== 64'(exp_d[k])) begin
        errors++; $display("FAIL rr_blk %0d: got v=%b w=%0d d=%h want w=%0d d=%h", k, iss_valid, iss_wid, iss_data, exp_w[k], exp_d[k]); end
    end
    tick();
    vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rr_blk_tail: got %b want 0", iss_valid); end
  endtask

  task automatic test_full();
    do_reset();
    set_dec(0, 0, 0, 0, 0, 0, 64'hA0); tick();
    idle(); tick();
    vectors++; if (iss_valid !== 1'b1 || iss_wid !== 2'd0) begin errors++; $display("FAIL full_hold: got v=%b w=%0d want v=1 w=0", iss_valid, iss_wid); end
    for (int k = 0; k < 4; k++) begin
      set_dec(3, 0, 0, 0, 0, 0, 64'(32'hD0 + k)); #1;
      vectors++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL full_ready %0d: got %b want 1", k, dec_ready); end
      tick();
    end
    set_dec(3, 0, 0, 0, 0, 0, 64'hD4);
    for (int s = 0; s < 3; s++) begin
      #1;
      vectors++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL full_stall %0d: got %b want 0", s, dec_ready); end
      tick();
    end
    idle(); iss_ready = 1'b1;
`ifdef ISSUE_PERF_EN
    vectors++; if (perf_ibf_stalls !== PCB'(3)) begin errors++; $display("FAIL perf_ibf: got %0d want 3", perf_ibf_stalls); end
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (iss_valid !== 1'b1 || iss_wid !== 2'd3 || iss_data !== 64'(32'hD0 + k)) begin
        errors++; $display("FAIL full_order %0d: got v=%b w=%0d d=%h want w=3 d=%h", k, iss_valid, iss_wid, iss_data, 32'hD0 + k); end
    end
    set_dec(3, 0, 0, 0, 0, 0, 64'hD4); #1;
    vectors++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", dec_ready); end
    tick(); idle(); tick();
    vectors++; if (iss_valid !== 1'b1 || iss_data !== 64'hD4) begin errors++; $display("FAIL full_last: got v=%b d=%h want v=1 d=d4", iss_valid, iss_data); end
  endtask

  task automatic test_same_edge();
    do_reset();
    iss_ready = 1'b1;
    set_dec(0, 1, 0, 0, 0, 0, 64'hE0); tick();
    set_dec(0, 0, 0, 0, 0, 0, 64'hE1); tick();
    idle(); tick();
    vectors++; if (iss_valid !== 1'b1 || iss_data !== 64'hE1) begin errors++; $display("FAIL r0_untracked: got v=%b d=%h want v=1 d=e1", iss_valid, iss_data); end
    set_dec(1, 1, 4, 0, 0, 0, 64'hF0); tick();
    // The writer of r4 is granted on this edge while a wb of r4 arrives.
    set_dec(1, 0, 0, 4, 0, 0, 64'hF1);
    wb_valid = 1'b1; wb_wid = 2'd1; wb_rd = 5'd4; wb_eop = 1'b1; tick();
    vectors++; if (iss_valid !== 1'b1 || iss_data !== 64'hF0) begin errors++; $display("FAIL se_writer: got v=%b d=%h want v=1 d=f0", iss_valid, iss_data); end
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL se_set_wins %0d: got %b want 0", k, iss_valid); end
    end
    wb_valid = 1'b1; wb_wid = 2'd1; wb_rd = 5'd4; wb_eop = 1'b1; tick();
    idle(); tick();
    vectors++; if (iss_valid !== 1'b1 || iss_data !== 64'hF1) begin errors++; $display("FAIL se_release: got v=%b d=%h want v=1 d=f1", iss_valid, iss_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 60)
        set_dec($urandom_range(0, NW - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                {$urandom, $urandom});
      else begin
        dec_valid = 1'b0; dec_wid = 2'($urandom_range(0, NW - 1));
      end
      iss_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 35) begin
        int w, r;
        w = $urandom_range(0, NW - 1);
        r = $urandom_range(0, 7);
        for (int q = 1; q < 8; q++) if (m_pend[w][q] && $urandom_range(0, 1) == 1) r = q;
        wb_valid = 1'b1; wb_wid = 2'(w); wb_rd = 5'(r); wb_eop = ($urandom_range(0, 9) < 8);
      end else begin
        wb_valid = 1'b0; wb_eop = 1'b0;
      end
      #1;
      vectors++; if (dec_ready !== (mq[int'(dec_wid)].size() != DEPTH)) begin
        errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, dec_ready, mq[int'(dec_wid)].size() != DEPTH); end
      tick();
      vectors++; if (iss_valid !== m_iv) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, iss_valid, m_iv); end
      if (m_iv) begin
        vectors++; if (iss_wid !== 2'(m_iwid) || iss_wb !== m_iss.wb || iss_rd !== 5'(m_iss.rd) || iss_data !== m_iss.data) begin
          errors++; $display("FAIL rnd_issue c%0d: got w=%0d wb=%b rd=%0d d=%h want w=%0d wb=%b rd=%0d d=%h", c,
                             iss_wid, iss_wb, iss_rd, iss_data, m_iwid, m_iss.wb, m_iss.rd, m_iss.data); end
      end
    end
    idle();
`ifdef ISSUE_PERF_EN
    vectors++; if (perf_ibf_stalls !== PCB'(m_ibf)) begin errors++; $display("FAIL rnd_perf_ibf: got %0d want %0d", perf_ibf_stalls, m_ibf); end
    vectors++; if (perf_scb_stalls !== PCB'(m_scb)) begin errors++; $display("FAIL rnd_perf_scb: got %0d want %0d", perf_scb_stalls, m_scb); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_raw();
    test_round_robin();
    test_full();
    test_same_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
